// File: rtl/ring_buff_drain_pkg.sv
// Shared types and helpers for the ring-buffer drain controller.
package ring_buff_drain_pkg;

    // Drain controller states: waiting for a burst trigger, or draining.
    typedef enum logic {
        DRN_IDLE  = 1'b0,
        DRN_DRAIN = 1'b1
    } drn_state_t;

    // Width of the payload carried by a forward token.
    localparam int TOKEN_DATA_W = 8;

    // Forward token: valid flag plus payload.
    typedef struct packed {
        logic                    v;
        logic [TOKEN_DATA_W-1:0] data;
    } FTk_t;

    // The 2-entry skid can take another token if it has room, or if its
    // head leaves in the same cycle the new token arrives.
    function automatic logic skid_can_accept(input logic [1:0] cnt, input logic pop);
        return (cnt < 2'd2) | pop;
    endfunction

endpackage

// File: rtl/ring_drain_skid.sv
// Two-entry registered skid FIFO between the buffer read port and the
// downstream link. Vacated entries are cleared, so head reads '0 when empty.
module ring_drain_skid
    import ring_buff_drain_pkg::*;
#(
    parameter type TYPE_FWRD = FTk_t
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  TYPE_FWRD data,
    input  logic     pop,
    output TYPE_FWRD head,
    output logic [1:0] cnt
);

    TYPE_FWRD   entry0_r;
    TYPE_FWRD   entry1_r;
    logic [1:0] cnt_r;

    // Entry/count update: entry0 is always the head, entry1 the second slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            entry0_r <= '0;
            entry1_r <= '0;
            cnt_r    <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    case (cnt_r)
                        2'd0: begin
                            entry0_r <= data;
                            cnt_r    <= 2'd1;
                        end
                        2'd1: begin
                            entry1_r <= data;
                            cnt_r    <= 2'd2;
                        end
                        default: begin
                            cnt_r <= cnt_r;
                        end
                    endcase
                end
                2'b01: begin
                    if (cnt_r != 2'd0) begin
                        entry0_r <= entry1_r;
                        entry1_r <= '0;
                        cnt_r    <= cnt_r - 2'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                2'b11: begin
                    case (cnt_r)
                        2'd2: begin
                            entry0_r <= entry1_r;
                            entry1_r <= data;
                        end
                        default: begin
                            // One entry (replace head) or none (pop ignored).
                            entry0_r <= data;
                            cnt_r    <= 2'd1;
                        end
                    endcase
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign head = entry0_r;
    assign cnt  = cnt_r;

endmodule

// File: rtl/ring_buff_drain.sv
// Consumer-side ring buffer controller: decides when to drain in bursts,
// issues read-enables, and forwards tokens downstream under nack back-pressure.
module ring_buff_drain
    import ring_buff_drain_pkg::*;
#(
    parameter int  DEPTH_BUFF  = 16,
    parameter int  WIDTH_DEPTH = $clog2(DEPTH_BUFF),
    parameter type TYPE_FWRD   = FTk_t,
    parameter int  THRESH      = 4,
    parameter int  TIMEOUT     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Empty,
    input  logic [WIDTH_DEPTH:0] I_Num,
    input  TYPE_FWRD             I_FTk,
    output logic                 O_Re,
    input  logic                 I_Flush,
    output TYPE_FWRD             O_FTk,
    input  logic                 I_Nack,
    output logic                 O_Busy,
    output logic [15:0]          O_Sent
);

    localparam int NUM_W   = WIDTH_DEPTH + 1;
    // The dwell counter never exceeds TIMEOUT-1 before a burst is forced.
    localparam int DWELL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    drn_state_t         state_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [15:0]        sent_r;

    logic       pop_s;
    logic       re_s;
    logic       start_s;
    logic       drain_done_s;
    TYPE_FWRD   push_data_s;
    TYPE_FWRD   skid_head_s;
    logic [1:0] skid_cnt_s;

    // Handshake, read-enable and burst-trigger decisions for this cycle.
    always_comb begin
        pop_s       = (skid_cnt_s != 2'd0) & ~I_Nack;
        re_s        = (state_r == DRN_DRAIN) & ~I_Empty & skid_can_accept(skid_cnt_s, pop_s);
        push_data_s = I_FTk;
        push_data_s.v = 1'b1;
        start_s     = (I_Num >= NUM_W'(THRESH))
                    | (I_Flush & ~I_Empty)
                    | ((dwell_r == DWELL_W'(TIMEOUT - 1)) & ~I_Empty);
        drain_done_s = I_Empty & (skid_cnt_s == 2'd0) & ~re_s;
    end

    // Burst FSM with the dwell counter that forces a burst for a lingering low fill.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= DRN_IDLE;
            dwell_r <= '0;
        end else begin
            case (state_r)
                DRN_IDLE: begin
                    if (start_s) begin
                        state_r <= DRN_DRAIN;
                        dwell_r <= '0;
                    end else if (I_Empty) begin
                        dwell_r <= '0;
                    end else begin
                        dwell_r <= dwell_r + DWELL_W'(1);
                    end
                end
                DRN_DRAIN: begin
                    dwell_r <= '0;
                    if (drain_done_s) begin
                        state_r <= DRN_IDLE;
                    end else begin
                        state_r <= DRN_DRAIN;
                    end
                end
                default: begin
                    state_r <= DRN_IDLE;
                    dwell_r <= '0;
                end
            endcase
        end
    end

    // Count of tokens accepted downstream, wrapping at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            sent_r <= 16'd0;
        end else if (pop_s) begin
            sent_r <= sent_r + 16'd1;
        end else begin
            sent_r <= sent_r;
        end
    end

    ring_drain_skid #(
        .TYPE_FWRD (TYPE_FWRD)
    ) u_skid (
        .clock (clock),
        .reset (reset),
        .push  (re_s),
        .data  (push_data_s),
        .pop   (pop_s),
        .head  (skid_head_s),
        .cnt   (skid_cnt_s)
    );

    assign O_Re   = re_s;
    assign O_FTk  = skid_head_s;
    assign O_Busy = (state_r != DRN_IDLE) | (skid_cnt_s != 2'd0);
    assign O_Sent = sent_r;

endmodule

// File: tb/tb_ring_buff_drain.sv
// Scoreboard bench for ring_buff_drain: a behavioural ring buffer feeds the
// DUT, writes push expected tokens, and a negedge monitor checks the link.
module tb_ring_buff_drain;
    import ring_buff_drain_pkg::*;

    logic       clock;
    logic       reset;
    logic       I_Empty;
    logic [4:0] I_Num;
    FTk_t       I_FTk;
    logic       O_Re;
    logic       I_Flush;
    FTk_t       O_FTk;
    logic       I_Nack;
    logic       O_Busy;
    logic [15:0] O_Sent;

    ring_buff_drain #(
        .DEPTH_BUFF (16),
        .TYPE_FWRD  (FTk_t),
        .THRESH     (4),
        .TIMEOUT    (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .I_Empty (I_Empty),
        .I_Num   (I_Num),
        .I_FTk   (I_FTk),
        .O_Re    (O_Re),
        .I_Flush (I_Flush),
        .O_FTk   (O_FTk),
        .I_Nack  (I_Nack),
        .O_Busy  (O_Busy),
        .O_Sent  (O_Sent)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Behavioural ring buffer
    logic [7:0] buf_mem [16];
    logic [3:0] buf_rd, buf_wr;
    logic [4:0] buf_cnt;
    logic       buf_clr, wr_en, stream_mode;
    logic [7:0] wr_data, stream_data;
    wire        buf_rd_s = O_Re && (buf_cnt != 5'd0);
    wire        buf_wr_s = wr_en || (stream_mode && ((buf_cnt < 5'd16) || buf_rd_s));

    assign I_Empty = (buf_cnt == 5'd0);
    assign I_Num   = buf_cnt;
    assign I_FTk   = FTk_t'({1'b0, buf_mem[buf_rd]});

    always @(posedge clock) begin
        if (buf_clr) begin
            buf_rd <= 4'd0; buf_wr <= 4'd0; buf_cnt <= 5'd0; stream_data <= 8'd0;
        end else begin
            if (buf_rd_s) buf_rd <= buf_rd + 4'd1;
            if (buf_wr_s) begin
                buf_mem[buf_wr] <= stream_mode ? stream_data : wr_data;
                buf_wr <= buf_wr + 4'd1;
                stream_data <= stream_data + 8'd1;
            end
            buf_cnt <= buf_cnt + {4'd0, buf_wr_s} - {4'd0, buf_rd_s};
        end
    end

    // Scoreboard and monitor
    logic [7:0]  exp_q[$];
    logic [31:0] sent_model;
    logic        prev_hold, re_prev;
    FTk_t        prev_tok;
    int          dwell_obs, last_wait;

    always @(negedge clock) begin
        if (reset) begin
            sent_model <= 32'd0; prev_hold <= 1'b0; re_prev <= 1'b0; dwell_obs <= 0;
        end else begin
            if (O_Re) check("re_while_empty", {31'd0, I_Empty}, 32'd0);
            if (prev_hold) check("nack_hold", {23'd0, O_FTk}, {23'd0, prev_tok});
            if (O_FTk.v && !I_Nack) begin
                check("sent_count", {16'd0, O_Sent}, {16'd0, sent_model[15:0]});
                if (!stream_mode) begin
                    check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) check("token_order", {24'd0, O_FTk.data}, {24'd0, exp_q.pop_front()});
                end
                sent_model <= sent_model + 32'd1;
            end
            prev_hold <= O_FTk.v & I_Nack;
            prev_tok  <= O_FTk;
            if (I_Empty) dwell_obs <= 0;
            else if (O_Re && !re_prev) begin last_wait <= dwell_obs; dwell_obs <= 0; end
            else if (!O_Busy && !O_Re) dwell_obs <= dwell_obs + 1;
            re_prev <= O_Re;
        end
    end

    task automatic write_tok(input logic [7:0] d);
        @(posedge clock); #1;
        wr_en = 1'b1; wr_data = d;
        exp_q.push_back(d);
    endtask

    task automatic end_writes();
        @(posedge clock); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (I_Empty && !O_Busy) begin done = 1'b1; break; end
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int re_cnt, first_re, last_re;
        logic found;
        reset = 1'b1; buf_clr = 1'b1; wr_en = 1'b0; wr_data = 8'd0;
        stream_mode = 1'b0; I_Flush = 1'b0; I_Nack = 1'b0;
        last_wait = -1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_re",   {31'd0, O_Re}, 32'd0);
        check("rst_ftk",  {23'd0, O_FTk}, 32'd0);
        check("rst_busy", {31'd0, O_Busy}, 32'd0);
        check("rst_sent", {16'd0, O_Sent}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; buf_clr = 1'b0;

        // 1: three tokens below THRESH; 8 idle dwell samples (0..7), reads start next
        write_tok(8'h11); write_tok(8'h12); write_tok(8'h13); end_writes();
        wait_quiet("t1_quiet");
        check("t1_dwell", last_wait, 32'd8);
        check("t1_sent", {16'd0, O_Sent}, 32'd3);

        // 2: fill to THRESH; four back-to-back reads
        write_tok(8'h21); write_tok(8'h22); write_tok(8'h23); write_tok(8'h24); end_writes();
        re_cnt = 0; first_re = -1; last_re = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (O_Re) begin
                re_cnt++;
                if (first_re < 0) first_re = i;
                last_re = i;
            end
        end
        check("t2_re_count", re_cnt, 32'd4);
        check("t2_re_span", last_re - first_re, 32'd3);
        check("t2_dwell", last_wait, 32'd4);
        check("t2_busy", {31'd0, O_Busy}, 32'd0);
        check("t2_sent", {16'd0, O_Sent}, 32'd7);

        // 3: burst of six with three nack cycles; reads stop once the skid is full
        write_tok(8'h31); write_tok(8'h32); write_tok(8'h33);
        write_tok(8'h34); write_tok(8'h35); write_tok(8'h36);
        re_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            wr_en = 1'b0; I_Nack = 1'b1;
            @(negedge clock);
            if (O_Re) re_cnt++;
        end
        @(posedge clock); #1;
        I_Nack = 1'b0;
        check("t3_re_in_nack", re_cnt, 32'd1);
        wait_quiet("t3_quiet");
        check("t3_sent", {16'd0, O_Sent}, 32'd13);
        check("t3_no_loss", exp_q.size(), 32'd0);

        // 4: single token with flush; busy drops one cycle after the accept
        write_tok(8'h41); I_Flush = 1'b1; end_writes();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (O_FTk.v) begin found = 1'b1; break; end
        end
        check("t4_token_seen", {31'd0, found}, 32'd1);
        @(negedge clock);
        check("t4_busy_after_accept", {31'd0, O_Busy}, 32'd1);
        @(negedge clock);
        check("t4_busy_fall", {31'd0, O_Busy}, 32'd0);
        check("t4_dwell", last_wait, 32'd1);
        check("t4_sent", {16'd0, O_Sent}, 32'd14);
        @(posedge clock); #1;
        I_Flush = 1'b0;

        // 5: reset with a full skid
        I_Nack = 1'b1;
        write_tok(8'h51); write_tok(8'h52); write_tok(8'h53);
        write_tok(8'h54); write_tok(8'h55); write_tok(8'h56); end_writes();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (O_FTk.v && !O_Re && !I_Empty) begin found = 1'b1; break; end
        end
        check("t5_skid_full", {31'd0, found}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1; buf_clr = 1'b1; exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        check("t5_ftk",  {23'd0, O_FTk}, 32'd0);
        check("t5_re",   {31'd0, O_Re}, 32'd0);
        check("t5_sent", {16'd0, O_Sent}, 32'd0);
        check("t5_busy", {31'd0, O_Busy}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; buf_clr = 1'b0; I_Nack = 1'b0;

        // 6: stream 65537 accepted tokens; the counter wraps to 1
        stream_mode = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clock); #1;
            if (sent_model >= 32'd65537) break;
        end
        check("t6_stream_done", {31'd0, sent_model >= 32'd65537}, 32'd1);
        stream_mode = 1'b0; I_Nack = 1'b1;
        @(negedge clock);
        check("t6_sent_wrap", {16'd0, O_Sent}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
